// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction+data memory between
// the core fetch port and its load/store port. Accesses are serialized
// through IDLE -> ISSUE -> (WAIT) -> RESP. Data wins by default, and a
// saturating streak counter forces a fetch grant after MAX_DATA_STREAK
// back-to-back data grants taken while a fetch was waiting.
module mem_port_arbiter #(
    parameter int MEM_LATENCY     = 1,   // 1..7
    parameter int MAX_DATA_STREAK = 4    // 1..15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // fetch port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    // load/store port
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_d_rdata,
    output logic        o_d_valid,
    // memory pins
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT        = 3'(MEM_LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t      r_state;
    state_t      w_next_state;

    // latched winner of the current access
    logic        r_src_d;      // 1 = data port, 0 = fetch port
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [2:0]  r_cnt;        // remaining read latency cycles
    logic [3:0]  r_streak;     // data grants taken while a fetch waited
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_last_wait;
    logic        w_accept;
    logic [31:0] w_sel_addr;

    // Arbitration decode: data wins unless the fetch port has been starved
    // for MAX_DATA_STREAK data grants in a row.
    always_comb begin
        w_any_req   = i_if_req | i_d_req;
        w_grant_d   = i_d_req & ~(i_if_req & (r_streak == STREAK_MAX));
        w_sel_addr  = w_grant_d ? i_d_addr : i_if_addr;
        w_accept    = (r_state == S_IDLE) & w_any_req;
        w_last_wait = (r_state == S_WAIT) & (r_cnt == 3'd1);
    end

    // State register; reset aborts any in-flight access.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = r_we ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 3'd1) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch the winner's request; the address is word-aligned here so the
    // memory pins come straight from a register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_src_d <= w_grant_d;
            r_we    <= w_grant_d & i_d_we;
            r_addr  <= w_sel_addr & 32'hFFFF_FFFC;
            r_wdata <= (w_grant_d & i_d_we) ? i_d_wdata : 32'h0;
        end
    end

    // Read latency counter: loaded at issue, counts down through WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst)                     r_cnt <= 3'd0;
        else if (r_state == S_ISSUE)   r_cnt <= LAT;
        else if (r_state == S_WAIT)    r_cnt <= r_cnt - 3'd1;
    end

    // Capture read data into the winner's return register when it is due.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
        end else if (w_last_wait) begin
            if (r_src_d) r_d_rdata  <= i_mem_rdata;
            else         r_if_rdata <= i_mem_rdata;
        end
    end

    // Starvation counter: only data grants that bypass a waiting fetch count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_streak <= 4'd0;
        end else if (w_accept) begin
            if (w_grant_d && i_if_req)
                r_streak <= (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
            else
                r_streak <= 4'd0;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        o_if_valid  = 1'b0;
        o_d_valid   = 1'b0;
        o_if_rdata  = r_if_rdata;
        o_d_rdata   = r_d_rdata;
        o_busy      = (r_state != S_IDLE);
        if (r_state == S_ISSUE) begin
            o_mem_en    = 1'b1;
            o_mem_we    = r_we;
            o_mem_addr  = r_addr;
            o_mem_wdata = r_wdata;
        end
        if (r_state == S_RESP) begin
            o_if_valid = ~r_src_d;
            o_d_valid  = r_src_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port unified memory between the rv32i_top instruction-fetch port and its load/store data port. Each port uses a hold-until-valid request handshake. The arbiter:
- serializes accesses;
- drives the memory pins;
- returns read data with a one-cycle valid pulse.

Data accesses win by default, and a streak counter guarantees fetch forward progress. It sits between the core's `pc`/`mem_addr` side and the shared instruction-plus-data memory array.

## Interface
- `MEM_LATENCY`, default 1 — cycles from read issue (`mem_en`=1, `mem_we`=0) until `mem_rdata` is valid; legal range 1..7.
- `MAX_DATA_STREAK`, default 4 — consecutive data grants allowed while a fetch is pending; legal range 1..15.
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `if_req` in 1 — fetch request.
- `if_addr` in 32 — fetch byte address.
- `if_rdata` out 32 — fetched instruction, meaningful only while `if_valid`=1.
- `if_valid` out 1 — one-cycle completion pulse for the fetch port.
- `d_req` in 1 — data request.
- `d_we` in 1 — 1 = store, 0 = load.
- `d_addr` in 32 — data byte address.
- `d_wdata` in 32 — store data.
- `d_rdata` out 32 — load data, meaningful only while `d_valid`=1.
- `d_valid` out 1 — one-cycle completion pulse for the data port.
- `mem_en` out 1 — memory access strobe, one cycle per access.
- `mem_we` out 1 — memory write enable, qualified by `mem_en`.
- `mem_addr` out 32 — granted address with bits [1:0] forced to 0.
- `mem_wdata` out 32 — store data.
- `mem_rdata` in 32 — memory read data.
- `busy` out 1 — 1 whenever the state is not IDLE.

## Operation
- Request protocol:
  - A requester raises `x_req` with `x_addr`/`x_we`/`x_wdata` stable, and holds all of them through the cycle in which `x_valid`=1.
  - `x_req`=1 in the cycle after `x_valid` is a new request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With no request, all `mem_*` outputs are 0 and the state stays IDLE.
  - With any request, select a winner, latch its address/we/wdata and source, and go to ISSUE.
- ISSUE:
  - Drive `mem_en`=1 with the latched `mem_we`/`mem_addr`/`mem_wdata` for exactly this cycle.
  - A write goes to RESP.
  - A read loads the latency counter with `MEM_LATENCY` and goes to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reaches 0 (i.e. `MEM_LATENCY` cycles after ISSUE), capture `mem_rdata` into the winner's rdata register and go to RESP.
- RESP:
  - Pulse the winner's `x_valid`=1 for one cycle, then go to IDLE.
  - For a write, `x_rdata` holds its previous value.
- Arbitration in IDLE:
  - Only `d_req` set: data wins.
  - Only `if_req` set: fetch wins.
  - Both set: data wins unless `streak`==`MAX_DATA_STREAK`, in which case fetch wins.
- `streak` counter (4 bits, saturating):
  - +1 on a data grant while `if_req`=1.
  - Cleared to 0 on a fetch grant.
  - Cleared to 0 on a data grant while `if_req`=0.
- `mem_wdata` is 0 for reads.
- Outputs other than the memory pins and `x_valid` are held between accesses.
- Reset mid-operation:
  - `rst`=1 returns to IDLE immediately at the next edge, clears `streak`, and aborts any in-flight access.
  - No `x_valid` is produced for the aborted access.
  - Late `mem_rdata` is ignored.
  - Requesters re-issue after reset.

## Timing
- Reset values: `if_valid`=0, `d_valid`=0, `if_rdata`=0, `d_rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `streak`=0, state IDLE.
- Request first sampled in IDLE at cycle T:
  - `mem_en` is high at T+1.
  - A write completes with `x_valid` at T+2.
  - A read completes with `x_valid` at T+2+`MEM_LATENCY`.
- Back-to-back throughput:
  - Writes: one access per 3 cycles.
  - Reads: one access per 3+`MEM_LATENCY` cycles.
- All outputs are registered or decoded only from registered state. There is no combinational path from `x_req`/`x_addr` to `mem_*`.
- `if_valid` and `d_valid` are never high in the same cycle.

## Test plan
- Reset release, no requests, 10 cycles: all outputs stay 0 and `busy`=0.
- Single fetch, `if_addr`=0x0000_0008, memory word 2 = 0x00500093, `MEM_LATENCY`=1, `if_req` first sampled at T:
  - `mem_en`=1 with `mem_addr`=0x8 at T+1.
  - `if_valid`=1 with `if_rdata`=0x00500093 at T+3, for exactly one cycle.
- Single store, `d_addr`=0x0000_0013, `d_wdata`=0xDEADBEEF:
  - `mem_we`=1 with `mem_addr`=0x10 at T+1.
  - `d_valid` at T+2.
  - A following load from 0x10 returns 0xDEADBEEF.
- Both ports requesting continuously, `MAX_DATA_STREAK`=2, data re-requesting immediately after each `d_valid`: grant order is D, D, F, D, D, F…; no fetch waits more than 2 data accesses.
- Simultaneous first requests from a clean reset: data is served first, fetch is served second, and the `if_valid`/`d_valid` pulses are disjoint.
- `rst` asserted during WAIT with `MEM_LATENCY`=3:
  - Next cycle is IDLE with all outputs 0.
  - No valid pulse for the aborted read.
  - A re-issued fetch completes normally.
